// File: rtl/sram_bus_ctrl_if.sv
// Bundle of the CPU-side request ports and the two SRAM bank pin groups
// handled by sram_bus_ctrl.
//   Core side : if_req/if_addr -> if_rdata/if_ack (fetch, read only)
//               mem_req/mem_we/mem_sel/mem_addr/mem_wdata -> mem_rdata/mem_ack
//   SRAM side : <bank>_ram_addr/be_n/ce_n/oe_n/we_n/wdata/data_oe out,
//               <bank>_ram_rdata in, for bank = base, ext
// Modport slave is the controller's view; master is the core/board view.
interface sram_bus_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              if_req;
  logic [31:0]       if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [ADDR_W-1:0] base_ram_addr,  ext_ram_addr;
  logic [SEL_W-1:0]  base_ram_be_n,  ext_ram_be_n;
  logic              base_ram_ce_n,  ext_ram_ce_n;
  logic              base_ram_oe_n,  ext_ram_oe_n;
  logic              base_ram_we_n,  ext_ram_we_n;
  logic [DATA_W-1:0] base_ram_wdata, ext_ram_wdata;
  logic              base_ram_data_oe, ext_ram_data_oe;
  logic [DATA_W-1:0] base_ram_rdata, ext_ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           base_ram_rdata, ext_ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack,
           base_ram_addr, base_ram_be_n, base_ram_ce_n, base_ram_oe_n,
           base_ram_we_n, base_ram_wdata, base_ram_data_oe,
           ext_ram_addr, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n,
           ext_ram_we_n, ext_ram_wdata, ext_ram_data_oe
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           base_ram_rdata, ext_ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
           base_ram_addr, base_ram_be_n, base_ram_ce_n, base_ram_oe_n,
           base_ram_we_n, base_ram_wdata, base_ram_data_oe,
           ext_ram_addr, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n,
           ext_ram_we_n, ext_ram_wdata, ext_ram_data_oe
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Sequenced two-port (fetch / data), two-bank (base / ext) asynchronous SRAM
// controller. One transaction at a time: arbitration in IDLE, then a read
// (RD) or a write (WR_SETUP, WR_PULSE, WR_HOLD), then a one-cycle ack (DONE).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sram_bus_ctrl_if.slave (core request ports and both SRAM banks)
// Every output comes straight from a flop: strobes are computed from the
// next state and registered together with it.
module sram_bus_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int BANK_BIT    = 22
) (
  input  logic clk,
  input  logic rst_n,
  sram_bus_ctrl_if.slave bus
);
  localparam int         SEL_W  = DATA_W / 8;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [3:0]        r_cnt, w_nxt_cnt;
  logic              r_port_mem, w_nxt_port_mem;   // 1 = MEM owns the transaction
  logic              r_last_mem;                   // previous grant went to MEM
  logic              r_bank, w_nxt_bank;           // 1 = ext bank
  logic [SEL_W-1:0]  r_sel, w_nxt_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_grant_mem, w_grant_if;

  logic              w_ce_n, w_oe_n, w_we_n, w_doe, w_if_ack, w_mem_ack;
  logic [SEL_W-1:0]  w_be_n;

  logic              r_base_ce_n, r_base_oe_n, r_base_we_n, r_base_doe;
  logic              r_ext_ce_n, r_ext_oe_n, r_ext_we_n, r_ext_doe;
  logic [SEL_W-1:0]  r_base_be_n, r_ext_be_n;
  logic              r_if_ack, r_mem_ack;
  logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;
  logic              w_unused;

  // Address bits outside the word address and bank bit are don't-care.
  assign w_unused = &{1'b0, bus.if_addr, bus.mem_addr};

  // Arbitration, next state and wait counter.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      IDLE: begin
        // MEM has priority, except IF is served right after a MEM grant.
        if (bus.mem_req && !(r_last_mem && bus.if_req)) begin
          w_grant_mem = 1'b1;
          w_nxt_state = bus.mem_we ? WR_SETUP : RD;
          w_nxt_cnt   = WAIT_L;
        end else if (bus.if_req) begin
          w_grant_if  = 1'b1;
          w_nxt_state = RD;
          w_nxt_cnt   = WAIT_L;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      RD: begin
        if (r_cnt == 4'd0) w_nxt_state = DONE;
        else               w_nxt_cnt   = r_cnt - 4'd1;
      end
      WR_SETUP: begin
        w_nxt_state = WR_PULSE;
        w_nxt_cnt   = WAIT_L;
      end
      WR_PULSE: begin
        if (r_cnt == 4'd0) w_nxt_state = WR_HOLD;
        else               w_nxt_cnt   = r_cnt - 4'd1;
      end
      WR_HOLD: w_nxt_state = DONE;
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Transaction fields as they will be after this edge (needed so the
  // registered strobes line up with the state they belong to).
  always_comb begin
    w_nxt_bank     = r_bank;
    w_nxt_sel      = r_sel;
    w_nxt_port_mem = r_port_mem;
    if (w_grant_mem) begin
      w_nxt_bank     = bus.mem_addr[BANK_BIT];
      w_nxt_sel      = bus.mem_sel;
      w_nxt_port_mem = 1'b1;
    end else if (w_grant_if) begin
      w_nxt_bank     = bus.if_addr[BANK_BIT];
      w_nxt_port_mem = 1'b0;
    end else begin
      w_nxt_port_mem = r_port_mem;
    end
  end

  // Strobe pattern for the next state, before bank steering.
  always_comb begin
    w_ce_n    = 1'b1;
    w_oe_n    = 1'b1;
    w_we_n    = 1'b1;
    w_doe     = 1'b0;
    w_be_n    = {SEL_W{1'b1}};
    w_if_ack  = 1'b0;
    w_mem_ack = 1'b0;
    case (w_nxt_state)
      RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = {SEL_W{1'b0}};
      end
      WR_SETUP, WR_HOLD: begin
        w_ce_n = 1'b0;
        w_doe  = 1'b1;
        w_be_n = ~w_nxt_sel;
      end
      WR_PULSE: begin
        w_ce_n = 1'b0;
        w_we_n = 1'b0;
        w_doe  = 1'b1;
        w_be_n = ~w_nxt_sel;
      end
      DONE: begin
        if (w_nxt_port_mem) w_mem_ack = 1'b1;
        else                w_if_ack  = 1'b1;
      end
      default: w_ce_n = 1'b1;
    endcase
  end

  // State, transaction latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_port_mem  <= 1'b0;
      r_last_mem  <= 1'b0;
      r_bank      <= 1'b0;
      r_sel       <= {SEL_W{1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_base_ce_n <= 1'b1;
      r_base_oe_n <= 1'b1;
      r_base_we_n <= 1'b1;
      r_base_doe  <= 1'b0;
      r_base_be_n <= {SEL_W{1'b1}};
      r_ext_ce_n  <= 1'b1;
      r_ext_oe_n  <= 1'b1;
      r_ext_we_n  <= 1'b1;
      r_ext_doe   <= 1'b0;
      r_ext_be_n  <= {SEL_W{1'b1}};
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_mem_rdata <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_port_mem <= w_nxt_port_mem;
      r_bank     <= w_nxt_bank;
      r_sel      <= w_nxt_sel;
      if (w_grant_mem) begin
        r_last_mem <= 1'b1;
        r_addr     <= bus.mem_addr[ADDR_W+1:2];
        r_wdata    <= bus.mem_wdata;
      end else if (w_grant_if) begin
        r_last_mem <= 1'b0;
        r_addr     <= bus.if_addr[ADDR_W+1:2];
      end
      // Only the selected bank sees the strobes; the other stays parked.
      r_base_ce_n <= w_nxt_bank ? 1'b1 : w_ce_n;
      r_base_oe_n <= w_nxt_bank ? 1'b1 : w_oe_n;
      r_base_we_n <= w_nxt_bank ? 1'b1 : w_we_n;
      r_base_doe  <= w_nxt_bank ? 1'b0 : w_doe;
      r_base_be_n <= w_nxt_bank ? {SEL_W{1'b1}} : w_be_n;
      r_ext_ce_n  <= w_nxt_bank ? w_ce_n : 1'b1;
      r_ext_oe_n  <= w_nxt_bank ? w_oe_n : 1'b1;
      r_ext_we_n  <= w_nxt_bank ? w_we_n : 1'b1;
      r_ext_doe   <= w_nxt_bank ? w_doe  : 1'b0;
      r_ext_be_n  <= w_nxt_bank ? w_be_n : {SEL_W{1'b1}};
      r_if_ack    <= w_if_ack;
      r_mem_ack   <= w_mem_ack;
      // Capture read data on the last RD cycle; it holds until the next one.
      if (r_state == RD && r_cnt == 4'd0) begin
        if (r_port_mem) r_mem_rdata <= r_bank ? bus.ext_ram_rdata : bus.base_ram_rdata;
        else            r_if_rdata  <= r_bank ? bus.ext_ram_rdata : bus.base_ram_rdata;
      end
    end
  end

  assign bus.base_ram_addr    = r_addr;
  assign bus.ext_ram_addr     = r_addr;
  assign bus.base_ram_wdata   = r_wdata;
  assign bus.ext_ram_wdata    = r_wdata;
  assign bus.base_ram_ce_n    = r_base_ce_n;
  assign bus.base_ram_oe_n    = r_base_oe_n;
  assign bus.base_ram_we_n    = r_base_we_n;
  assign bus.base_ram_be_n    = r_base_be_n;
  assign bus.base_ram_data_oe = r_base_doe;
  assign bus.ext_ram_ce_n     = r_ext_ce_n;
  assign bus.ext_ram_oe_n     = r_ext_oe_n;
  assign bus.ext_ram_we_n     = r_ext_we_n;
  assign bus.ext_ram_be_n     = r_ext_be_n;
  assign bus.ext_ram_data_oe  = r_ext_doe;
  assign bus.if_ack           = r_if_ack;
  assign bus.mem_ack          = r_mem_ack;
  assign bus.if_rdata         = r_if_rdata;
  assign bus.mem_rdata        = r_mem_rdata;
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: a WAIT_CYCLES=1 instance with behavioural
// base/ext SRAMs, plus WAIT_CYCLES=0 and =3 instances for latency checks.
module tb_sram_bus_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Shared request fields; each instance has its own request levels.
  logic [31:0] tb_if_addr, tb_mem_addr, tb_mem_wdata;
  logic        tb_mem_we;
  logic [3:0]  tb_mem_sel;
  logic        req1_if, req1_mem, req0_mem, req3_mem;

  sram_bus_ctrl_if #(.ADDR_W(20), .DATA_W(32)) i1 ();
  sram_bus_ctrl_if #(.ADDR_W(20), .DATA_W(32)) i0 ();
  sram_bus_ctrl_if #(.ADDR_W(20), .DATA_W(32)) i3 ();

  sram_bus_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1), .BANK_BIT(22))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  sram_bus_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0), .BANK_BIT(22))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  sram_bus_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(3), .BANK_BIT(22))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

  assign i1.if_req = req1_if;   assign i1.mem_req = req1_mem;
  assign i0.if_req = 1'b0;      assign i0.mem_req = req0_mem;
  assign i3.if_req = 1'b0;      assign i3.mem_req = req3_mem;
  assign i1.if_addr = tb_if_addr;  assign i1.mem_addr = tb_mem_addr;
  assign i0.if_addr = tb_if_addr;  assign i0.mem_addr = tb_mem_addr;
  assign i3.if_addr = tb_if_addr;  assign i3.mem_addr = tb_mem_addr;
  assign i1.mem_we = tb_mem_we;  assign i1.mem_sel = tb_mem_sel;  assign i1.mem_wdata = tb_mem_wdata;
  assign i0.mem_we = tb_mem_we;  assign i0.mem_sel = tb_mem_sel;  assign i0.mem_wdata = tb_mem_wdata;
  assign i3.mem_we = tb_mem_we;  assign i3.mem_sel = tb_mem_sel;  assign i3.mem_wdata = tb_mem_wdata;
  assign i0.base_ram_rdata = 32'h0BAD_F00D;  assign i0.ext_ram_rdata = 32'h0BAD_F00D;
  assign i3.base_ram_rdata = 32'h0BAD_F00D;  assign i3.ext_ram_rdata = 32'h0BAD_F00D;

  // Behavioural SRAMs for the WAIT_CYCLES=1 instance (64 words each).
  logic [31:0] base_mem [0:63];
  logic [31:0] ext_mem  [0:63];
  assign i1.base_ram_rdata = base_mem[i1.base_ram_addr[5:0]];
  assign i1.ext_ram_rdata  = ext_mem[i1.ext_ram_addr[5:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      base_mem[4] <= 32'hDEAD_BEEF;
      ext_mem[2]  <= 32'hAABB_CCDD;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!i1.base_ram_ce_n && !i1.base_ram_we_n && !i1.base_ram_be_n[b])
          base_mem[i1.base_ram_addr[5:0]][b*8 +: 8] <= i1.base_ram_wdata[b*8 +: 8];
        if (!i1.ext_ram_ce_n && !i1.ext_ram_we_n && !i1.ext_ram_be_n[b])
          ext_mem[i1.ext_ram_addr[5:0]][b*8 +: 8] <= i1.ext_ram_wdata[b*8 +: 8];
      end
    end
  end

  // Bus-contention watch: output enable together with driven data.
  int inv_viol = 0;
  always @(negedge clk) begin
    if ((!i1.base_ram_oe_n && i1.base_ram_data_oe) || (!i1.ext_ram_oe_n && i1.ext_ram_data_oe))
      inv_viol <= inv_viol + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations of the WAIT_CYCLES=1 instance.
  int n_base_ce, n_base_oe, n_base_we, n_base_doe;
  int n_ext_ce, n_ext_oe, n_ext_we, n_ext_doe;
  int n_ack_if, n_ack_mem, ack_cyc;
  logic [19:0] s_base_addr, s_ext_addr;
  logic [3:0]  s_base_be, s_ext_be;
  logic [31:0] s_rd;

  // One transaction on the W=1 instance, watched for 12 cycles after edge 0.
  task automatic run_w1(input logic is_mem, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
    n_base_ce = 0; n_base_oe = 0; n_base_we = 0; n_base_doe = 0;
    n_ext_ce = 0; n_ext_oe = 0; n_ext_we = 0; n_ext_doe = 0;
    n_ack_if = 0; n_ack_mem = 0; ack_cyc = -1; s_rd = 32'h0;
    s_base_addr = 20'h0; s_ext_addr = 20'h0; s_base_be = 4'hF; s_ext_be = 4'hF;
    if (is_mem) begin
      tb_mem_we = we; tb_mem_addr = addr; tb_mem_sel = sel; tb_mem_wdata = wd; req1_mem = 1'b1;
    end else begin
      tb_if_addr = addr; req1_if = 1'b1;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (!i1.base_ram_ce_n) begin n_base_ce++; s_base_addr = i1.base_ram_addr; s_base_be = i1.base_ram_be_n; end
      if (!i1.ext_ram_ce_n)  begin n_ext_ce++;  s_ext_addr  = i1.ext_ram_addr;  s_ext_be  = i1.ext_ram_be_n;  end
      if (!i1.base_ram_oe_n) n_base_oe++;
      if (!i1.ext_ram_oe_n)  n_ext_oe++;
      if (!i1.base_ram_we_n) n_base_we++;
      if (!i1.ext_ram_we_n)  n_ext_we++;
      if (i1.base_ram_data_oe) n_base_doe++;
      if (i1.ext_ram_data_oe)  n_ext_doe++;
      if (i1.if_ack) begin
        n_ack_if++;
        if (ack_cyc < 0) begin ack_cyc = k; s_rd = i1.if_rdata; end
        req1_if = 1'b0;
      end
      if (i1.mem_ack) begin
        n_ack_mem++;
        if (ack_cyc < 0) begin ack_cyc = k; s_rd = i1.mem_rdata; end
        req1_mem = 1'b0;
      end
    end
  endtask

  // Same transaction on the W=0 and W=3 instances; returns ack cycles.
  task automatic lat_03(input logic we, output int c0, output int c3, output logic [31:0] rd3);
    tb_mem_addr = 32'h0000_0030; tb_mem_we = we; tb_mem_sel = 4'hF; tb_mem_wdata = 32'h1;
    req0_mem = 1'b1; req3_mem = 1'b1; c0 = -1; c3 = -1; rd3 = 32'h0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); @(negedge clk);
      if (i0.mem_ack && c0 < 0) begin c0 = k; req0_mem = 1'b0; end
      if (i3.mem_ack && c3 < 0) begin c3 = k; rd3 = i3.mem_rdata; req3_mem = 1'b0; end
    end
  endtask

  int          idle_bad, n_acks, dbl_ack, c0, c3;
  logic [3:0]  order;
  logic        prev_ack;
  logic [31:0] rd3;

  initial begin
    rst_n = 1'b0;
    req1_if = 1'b0; req1_mem = 1'b0; req0_mem = 1'b0; req3_mem = 1'b0;
    tb_if_addr = 32'h0; tb_mem_addr = 32'h0; tb_mem_wdata = 32'h0;
    tb_mem_we = 1'b0; tb_mem_sel = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_strobes", {i1.base_ram_ce_n, i1.base_ram_oe_n, i1.base_ram_we_n,
                              i1.ext_ram_ce_n, i1.ext_ram_oe_n, i1.ext_ram_we_n}, 64'h3F);
    check_val("rst_oe_ack", {i1.base_ram_data_oe, i1.ext_ram_data_oe, i1.if_ack, i1.mem_ack}, 64'h0);
    check_val("rst_be_n", {i1.base_ram_be_n, i1.ext_ram_be_n}, 64'hFF);
    check_val("rst_addr", {i1.base_ram_addr, i1.ext_ram_addr}, 64'h0);
    check_val("rst_rdata", {i1.if_rdata, i1.mem_rdata}, 64'h0);
    check_val("rst_wdata", i1.base_ram_wdata, 64'h0);
    rst_n = 1'b1;

    // Idle for 20 cycles with no requests.
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (!(i1.base_ram_ce_n && i1.base_ram_oe_n && i1.base_ram_we_n &&
            i1.ext_ram_ce_n && i1.ext_ram_oe_n && i1.ext_ram_we_n) ||
          i1.base_ram_data_oe || i1.ext_ram_data_oe || i1.if_ack || i1.mem_ack)
        idle_bad++;
    end
    check_val("idle_quiet", idle_bad, 64'd0);

    // IF read of base word 4.
    run_w1(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    check_val("ifrd_ack_cyc", ack_cyc, 64'd3);
    check_val("ifrd_data", s_rd, 64'hDEAD_BEEF);
    check_val("ifrd_oe_cyc", n_base_oe, 64'd2);
    check_val("ifrd_ce_cyc", n_base_ce, 64'd2);
    check_val("ifrd_addr", s_base_addr, 64'd4);
    check_val("ifrd_be_n", s_base_be, 64'h0);
    check_val("ifrd_ext_quiet", n_ext_ce + n_ext_oe + n_ext_we, 64'd0);
    check_val("ifrd_acks", {n_ack_if[7:0], n_ack_mem[7:0]}, 64'h0100);
    check_val("ifrd_hold", i1.if_rdata, 64'hDEAD_BEEF);

    // MEM partial write to ext word 2.
    run_w1(1'b1, 1'b1, 32'h0040_0008, 4'b0011, 32'h1234_5678);
    check_val("wr_ack_cyc", ack_cyc, 64'd5);
    check_val("wr_we_cyc", n_ext_we, 64'd2);
    check_val("wr_doe_cyc", n_ext_doe, 64'd4);
    check_val("wr_ce_cyc", n_ext_ce, 64'd4);
    check_val("wr_be_n", s_ext_be, 64'hC);
    check_val("wr_addr", s_ext_addr, 64'd2);
    check_val("wr_oe_n_high", n_ext_oe, 64'd0);
    check_val("wr_base_quiet", n_base_ce + n_base_doe, 64'd0);
    check_val("wr_acks", {n_ack_if[7:0], n_ack_mem[7:0]}, 64'h0001);

    // Read back: low lanes new, high lanes untouched.
    run_w1(1'b1, 1'b0, 32'h0040_0008, 4'hF, 32'h0);
    check_val("rdback_ack_cyc", ack_cyc, 64'd3);
    check_val("rdback_data", s_rd, 64'hAABB_5678);

    // Make the last grant IF, then hold both requests.
    run_w1(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    check_val("ifrd2_data", s_rd, 64'hDEAD_BEEF);
    tb_if_addr = 32'h0000_0010; tb_mem_addr = 32'h0040_0008; tb_mem_we = 1'b0;
    req1_if = 1'b1; req1_mem = 1'b1;
    n_acks = 0; dbl_ack = 0; order = 4'h0; prev_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if ((i1.if_ack || i1.mem_ack) && prev_ack) dbl_ack++;
      prev_ack = i1.if_ack || i1.mem_ack;
      if (i1.mem_ack) begin order = {order[2:0], 1'b1}; n_acks++; end
      if (i1.if_ack)  begin order = {order[2:0], 1'b0}; n_acks++; end
      if (n_acks >= 4) begin req1_if = 1'b0; req1_mem = 1'b0; end
    end
    check_val("arb_count", n_acks, 64'd4);
    check_val("arb_order", order, 64'hA);
    check_val("arb_single_ack", dbl_ack, 64'd0);
    check_val("arb_if_data", i1.if_rdata, 64'hDEAD_BEEF);
    check_val("arb_mem_data", i1.mem_rdata, 64'hAABB_5678);

    // Reset during WR_PULSE of a base write.
    tb_mem_addr = 32'h0000_0020; tb_mem_we = 1'b1; tb_mem_sel = 4'hF; tb_mem_wdata = 32'h0000_0055;
    req1_mem = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_val("rstwr_pulse", i1.base_ram_we_n, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("rstwr_async", {i1.base_ram_ce_n, i1.base_ram_we_n, i1.base_ram_data_oe}, 64'h6);
    n_ack_mem = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (i1.mem_ack) n_ack_mem++;
    end
    check_val("rstwr_no_ack", n_ack_mem, 64'd0);
    rst_n = 1'b1;
    run_w1(1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_0055);
    check_val("rstwr_reaccept_ack", ack_cyc, 64'd5);
    check_val("rstwr_reaccept_we", n_base_we, 64'd2);
    run_w1(1'b0, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
    check_val("rstwr_readback", s_rd, 64'h0000_0055);
    check_val("contention", inv_viol, 64'd0);

    // Latency with WAIT_CYCLES = 0 and 3.
    lat_03(1'b0, c0, c3, rd3);
    check_val("w0_rd_ack", c0, 64'd2);
    check_val("w3_rd_ack", c3, 64'd5);
    check_val("w3_rd_data", rd3, 64'h0BAD_F00D);
    lat_03(1'b1, c0, c3, rd3);
    check_val("w0_wr_ack", c0, 64'd4);
    check_val("w3_wr_ack", c3, 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
